uart_wb_driver: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_wb_driver.sv | 197 +++++++++++++++++++
 tb/tb_uart_wb_driver.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART bus constants, FSM state and transaction encodings
package uart_pkg;

    localparam logic [1:0] UART_TX_ADDR  = 2'd0;
    localparam logic [1:0] UART_RX_ADDR  = 2'd1;
    localparam logic [1:0] UART_DIV_ADDR = 2'd2;

    // The UART decodes we inverted: low means write.
    localparam logic WE_WRITE = 1'b0;
    localparam logic WE_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_STB,
        ST_RELEASE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        WR_DIV,
        WR_TX,
        RD_RX
    } txn_t;

endpackage

// File: rtl/uart_wb_driver.sv
// rtl/uart_wb_driver.sv - Wishbone master programming and pacing the UART peripheral
//
// Ports:
//   wb_clk, reset              bus clock; synchronous active-high reset
//   in_data/in_valid/in_ready  byte stream to transmit (accepted on valid & ready)
//   rx_poll                    single-cycle request to read one RX byte
//   rx_data/rx_valid           received byte, rx_valid is a one-cycle pulse
//   wb_addr/wb_data_out/wb_we  bus request (we: 0 = write, 1 = read)
//   wb_stb/wb_ack/wb_data_in   strobe, UART ack (held until strobe drops), read data
//   busy                       FSM is not in IDLE
//   timeout_err                sticky ack timeout flag, cleared only by reset
module uart_wb_driver
    import uart_pkg::*;
#(
    parameter logic [7:0]  DIVIDER     = 8'd6,
    parameter logic [15:0] GAP_CYCLES  = 16'd1200,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd64
) (
    input  logic       wb_clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       rx_poll,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data_out,
    input  logic [7:0] wb_data_in,
    output logic       wb_we,
    output logic       wb_stb,
    input  logic       wb_ack,
    output logic       busy,
    output logic       timeout_err
);

    state_t      r_state;
    txn_t        r_txn;
    logic [15:0] r_gap_cnt;
    logic [7:0]  r_to_cnt;
    logic        r_poll;
    logic        r_stb;
    logic        r_we;
    logic [1:0]  r_addr;
    logic [7:0]  r_dout;
    logic        r_in_ready;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_busy;
    logic        r_err;

    state_t      w_state_nxt;
    txn_t        w_txn_nxt;
    logic [1:0]  w_addr_nxt;
    logic        w_we_nxt;
    logic [7:0]  w_dout_nxt;
    logic        w_stb_nxt;
    logic [7:0]  w_rx_data_nxt;
    logic        w_rx_valid_nxt;
    logic        w_err_set;
    logic        w_poll_clr;
    logic        w_to_done;
    logic        w_gap_done;

    assign w_to_done  = (r_to_cnt == ACK_TIMEOUT);
    assign w_gap_done = (r_gap_cnt == GAP_CYCLES);

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_txn      <= WR_DIV;
            r_gap_cnt  <= 16'd0;
            r_to_cnt   <= 8'd0;
            r_poll     <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= WE_READ;
            r_addr     <= 2'd0;
            r_dout     <= 8'd0;
            r_in_ready <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_txn      <= w_txn_nxt;
            r_stb      <= w_stb_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_dout     <= w_dout_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            // Outputs are registered from the next state so they line up with it.
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_err      <= r_err | w_err_set;
            // A poll landing on the clearing edge survives: set wins.
            r_poll     <= rx_poll | (r_poll & ~w_poll_clr);

            // Counters restart on each state entry and saturate at terminal count.
            if (w_state_nxt != r_state) begin
                r_gap_cnt <= 16'd0;
                r_to_cnt  <= 8'd0;
            end else begin
                if (!w_gap_done) begin
                    r_gap_cnt <= r_gap_cnt + 16'd1;
                end
                if (!w_to_done) begin
                    r_to_cnt <= r_to_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_txn_nxt      = r_txn;
        w_addr_nxt     = r_addr;
        w_we_nxt       = r_we;
        w_dout_nxt     = r_dout;
        w_stb_nxt      = 1'b0;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_err_set      = 1'b0;
        w_poll_clr     = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_txn_nxt   = WR_DIV;
                w_addr_nxt  = UART_DIV_ADDR;
                w_we_nxt    = WE_WRITE;
                w_dout_nxt  = DIVIDER;
                w_state_nxt = ST_STB;
            end

            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_txn_nxt   = WR_TX;
                    w_addr_nxt  = UART_TX_ADDR;
                    w_we_nxt    = WE_WRITE;
                    w_dout_nxt  = in_data;
                    w_state_nxt = ST_STB;
                end else if (r_poll) begin
                    w_txn_nxt   = RD_RX;
                    w_addr_nxt  = UART_RX_ADDR;
                    w_we_nxt    = WE_READ;
                    w_state_nxt = ST_STB;
                end
            end

            ST_STB: begin
                if (wb_ack) begin
                    w_state_nxt = ST_RELEASE;
                    if (r_txn == RD_RX) begin
                        w_rx_data_nxt  = wb_data_in;
                        w_rx_valid_nxt = 1'b1;
                        w_poll_clr     = 1'b1;
                    end
                end else if (w_to_done) begin
                    w_state_nxt = ST_RELEASE;
                    w_err_set   = 1'b1;
                    w_poll_clr  = (r_txn == RD_RX);
                end else begin
                    w_stb_nxt = 1'b1;
                end
            end

            ST_RELEASE: begin
                if (!wb_ack || w_to_done) begin
                    w_err_set   = wb_ack;
                    w_state_nxt = (r_txn == WR_TX) ? ST_GAP : ST_IDLE;
                end
            end

            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign in_ready    = r_in_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign wb_addr     = r_addr;
    assign wb_data_out = r_dout;
    assign wb_we       = r_we;
    assign wb_stb      = r_stb;
    assign busy        = r_busy;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_uart_wb_driver.sv
// tb/tb_uart_wb_driver.sv - self-checking bench for uart_wb_driver with a behavioural UART
module tb_uart_wb_driver;
    import uart_pkg::*;

    logic       wb_clk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       rx_poll = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_ack;
    logic       busy;
    logic       timeout_err;

    uart_wb_driver dut (
        .wb_clk      (wb_clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rx_poll     (rx_poll),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .wb_addr     (wb_addr),
        .wb_data_out (wb_data_out),
        .wb_data_in  (wb_data_in),
        .wb_we       (wb_we),
        .wb_stb      (wb_stb),
        .wb_ack      (wb_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 wb_clk = ~wb_clk;

    int cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    // Behavioural UART: acks one cycle after seeing stb, holds ack until stb drops.
    logic       r_ack = 1'b0;
    logic       ack_en = 1'b1;
    logic [7:0] uart_div = 8'd0;
    logic [7:0] uart_rx = 8'd0;
    logic [7:0] tx_log[$];
    int         n_wr = 0;
    int         n_rd = 0;
    int         last_wr_cyc = 0;
    int         last_rd_cyc = 0;
    logic [1:0] last_addr = 2'd0;
    logic [7:0] last_wdata = 8'd0;

    always @(posedge wb_clk) begin
        if (reset) begin
            r_ack    <= 1'b0;
            uart_div <= 8'd0;
        end else if (!wb_stb) begin
            r_ack <= 1'b0;
        end else if (ack_en && !r_ack) begin
            r_ack     <= 1'b1;
            last_addr <= wb_addr;
            if (wb_we == WE_WRITE) begin
                n_wr        <= n_wr + 1;
                last_wr_cyc <= cyc;
                last_wdata  <= wb_data_out;
                if (wb_addr == UART_DIV_ADDR) uart_div <= wb_data_out;
                if (wb_addr == UART_TX_ADDR) tx_log.push_back(wb_data_out);
            end else begin
                n_rd        <= n_rd + 1;
                last_rd_cyc <= cyc;
            end
        end
    end
    assign wb_ack     = r_ack;
    assign wb_data_in = (wb_addr == UART_RX_ADDR) ? uart_rx : 8'hEE;

    int         n_rxv = 0;
    int         n_stb_rise = 0;
    logic [7:0] last_rx = 8'd0;
    logic       stb_d = 1'b0;
    always @(negedge wb_clk) begin
        if (rx_valid) begin
            n_rxv   <= n_rxv + 1;
            last_rx <= rx_data;
        end
        if (wb_stb && !stb_d) n_stb_rise <= n_stb_rise + 1;
        stb_d <= wb_stb;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // Quiet = in_ready held for 8 consecutive cycles (covers pending polls).
    task automatic wait_quiet(input string name);
        int run;
        run = 0;
        for (int i = 0; i < 6000 && run < 8; i++) begin
            tick();
            if (in_ready) run = run + 1;
            else run = 0;
        end
        chk({name, "_quiet"}, run >= 8, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        acc_cyc  = -1;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (in_ready) begin
                tick();
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", acc_cyc >= 0, 1);
    endtask

    typedef struct {
        bit         do_tx;
        logic [7:0] tx;
        int         npoll;
        logic [7:0] rxb;
        int         exp_rd;
        int         exp_rxv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int c_rel, k, k2, n0, nwr0, nrd0, nrxv0, ntx0, nrise0, cnt;

        vecs[0] = '{do_tx: 1'b0, tx: 8'h00, npoll: 1, rxb: 8'h5A, exp_rd: 1, exp_rxv: 1};
        vecs[1] = '{do_tx: 1'b1, tx: 8'hC3, npoll: 0, rxb: 8'h00, exp_rd: 0, exp_rxv: 0};
        vecs[2] = '{do_tx: 1'b1, tx: 8'h7E, npoll: 1, rxb: 8'hA5, exp_rd: 1, exp_rxv: 1};
        vecs[3] = '{do_tx: 1'b0, tx: 8'h00, npoll: 3, rxb: 8'h3C, exp_rd: 1, exp_rxv: 1};
        vecs[4] = '{do_tx: 1'b1, tx: 8'h11, npoll: 3, rxb: 8'h96, exp_rd: 1, exp_rxv: 1};

        // Reset values.
        repeat (3) tick();
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 1);
        chk("rst_addr", wb_addr, 0);
        chk("rst_dout", wb_data_out, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_err", timeout_err, 0);

        // Divider write after reset release; the next edge is edge 0.
        reset = 1'b0;
        c_rel = cyc;
        tick();
        chk("init_stb_e0", wb_stb, 0);
        tick();
        chk("init_stb_e1", wb_stb, 1);
        chk("init_addr", wb_addr, UART_DIV_ADDR);
        chk("init_we", wb_we, WE_WRITE);
        chk("init_dout", wb_data_out, 8'h06);
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("init_busy_fall_le6", (cyc - c_rel) <= 6, 1);
        chk("init_in_ready", in_ready, 1);
        chk("init_nwr", n_wr, 1);
        chk("init_div", uart_div, 8'h06);
        chk("init_last_addr", last_addr, UART_DIV_ADDR);

        // Single TX handshake timing.
        send_byte(8'h33, k);
        chk("tx_k_ready", in_ready, 0);
        chk("tx_k_stb", wb_stb, 0);
        tick();
        chk("tx_k1_stb", wb_stb, 1);
        chk("tx_k1_addr", wb_addr, UART_TX_ADDR);
        chk("tx_k1_we", wb_we, WE_WRITE);
        chk("tx_k1_dout", wb_data_out, 8'h33);
        tick();
        chk("tx_k2_stb", wb_stb, 1);
        tick();
        chk("tx_k3_stb", wb_stb, 0);
        tick();
        tick();
        chk("tx_k5_busy", busy, 1);
        for (int i = 0; i < 3000 && !in_ready; i++) tick();
        chk("tx_ready_edge", cyc - k, 1206);
        chk("tx_log_33", tx_log[tx_log.size()-1], 8'h33);

        // Back-to-back stream.
        ntx0 = tx_log.size();
        send_byte(8'h48, k);
        send_byte(8'h69, k2);
        wait_quiet("stream");
        chk("stream_spacing", k2 - k, 1207);
        chk("stream_count", tx_log.size() - ntx0, 2);
        chk("stream_b0", tx_log[ntx0], 8'h48);
        chk("stream_b1", tx_log[ntx0+1], 8'h69);

        // Table-driven TX / poll vectors.
        for (int v = 0; v < 5; v++) begin
            uart_rx = vecs[v].rxb;
            nrd0  = n_rd;
            nrxv0 = n_rxv;
            ntx0  = tx_log.size();
            if (vecs[v].do_tx) begin
                in_data  = vecs[v].tx;
                in_valid = 1'b1;
            end
            if (vecs[v].npoll == 0) begin
                tick();
                in_valid = 1'b0;
            end
            for (int p = 0; p < vecs[v].npoll; p++) begin
                rx_poll = 1'b1;
                tick();
                in_valid = 1'b0;
            end
            rx_poll = 1'b0;
            wait_quiet($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_ntx", v), tx_log.size() - ntx0, vecs[v].do_tx);
            if (vecs[v].do_tx)
                chk($sformatf("vec%0d_txb", v), tx_log[tx_log.size()-1], vecs[v].tx);
            chk($sformatf("vec%0d_nrd", v), n_rd - nrd0, vecs[v].exp_rd);
            chk($sformatf("vec%0d_nrxv", v), n_rxv - nrxv0, vecs[v].exp_rxv);
            if (vecs[v].exp_rxv > 0) begin
                chk($sformatf("vec%0d_rxb", v), last_rx, vecs[v].rxb);
                chk($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].rxb);
            end
            if (vecs[v].do_tx && vecs[v].exp_rd > 0)
                chk($sformatf("vec%0d_rd_after_gap", v), (last_rd_cyc - last_wr_cyc) > 1200, 1);
        end

        // Ack timeout on an RX read.
        ack_en = 1'b0;
        nrd0   = n_rd;
        nrxv0  = n_rxv;
        nrise0 = n_stb_rise;
        rx_poll = 1'b1;
        tick();
        rx_poll = 1'b0;
        for (int i = 0; i < 20 && !wb_stb; i++) tick();
        chk("to_stb_rose", wb_stb, 1);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cnt = cnt + 1;
            if (!wb_stb) break;
        end
        chk("to_stb_cycles", cnt, 64);
        tick();
        chk("to_err_set", timeout_err, 1);
        ack_en = 1'b1;
        wait_quiet("to");
        chk("to_no_rxv", n_rxv - nrxv0, 0);
        chk("to_no_read", n_rd - nrd0, 0);
        chk("to_no_retry", n_stb_rise - nrise0, 1);
        ntx0 = tx_log.size();
        send_byte(8'h5C, k);
        wait_quiet("to_tx");
        chk("to_err_sticky", timeout_err, 1);
        chk("to_tx_ok", tx_log.size() - ntx0, 1);

        // Reset during an active strobe.
        nwr0 = n_wr;
        ntx0 = tx_log.size();
        send_byte(8'h99, k);
        tick();
        chk("mid_stb_high", wb_stb, 1);
        reset = 1'b1;
        tick();
        chk("mid_stb", wb_stb, 0);
        chk("mid_we", wb_we, 1);
        chk("mid_addr", wb_addr, 0);
        chk("mid_dout", wb_data_out, 0);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_rx_valid", rx_valid, 0);
        chk("mid_rx_data", rx_data, 0);
        chk("mid_busy", busy, 1);
        chk("mid_err", timeout_err, 0);
        reset = 1'b0;
        n0 = n_stb_rise;
        wait_quiet("mid");
        chk("mid_div_rewrite", n_wr - nwr0, 1);
        chk("mid_div_val", uart_div, 8'h06);
        chk("mid_div_addr", last_addr, UART_DIV_ADDR);
        chk("mid_tx_aborted", tx_log.size() - ntx0, 0);
        chk("mid_one_stb", n_stb_rise - n0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
